sim_finish_ctrl: RTL
====================

Name: sim_finish_ctrl

Overview:
- Simulation-only test-completion sequencer for the chip-level Verilator top.
- Arbitrates the sources that can end a run: SW test-status done/pass, legacy GPIO pass/fail patterns, a cycle watchdog and an external abort (DPI model error).
- Captures the first winning cause, runs a drain countdown so UART/log traffic can flush, then issues a single finish request.
- Keeps `$finish` policy out of the top level.

Parameters:
- DrainCycles, 7: cycles spent in DRAIN before finish; 0 means finish on the cycle after capture.
- TimeoutCycles, 32'd10_000_000: RUN cycles before the watchdog fires; 0 disables the watchdog.
- GpioPassPattern, 32'hDEADBEEF: GPIO value that signals pass.
- GpioFailPattern, 32'hBAADF00D: GPIO value that signals fail.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  arms monitoring; while low the block stays in IDLE.
- sw_test_done_i  in  1  SW test-status completion, level.
- sw_test_passed_i  in  1  SW pass/fail qualifier; valid when done is high.
- gpio_pins_i  in  32  masked GPIO outputs.
- abort_i  in  1  external fatal error, level.
- busy_o  out  1  high in RUN or DRAIN.
- done_o  out  1  a completion cause has been captured; sticky.
- passed_o  out  1  captured cause is a pass; valid while done_o is high.
- cause_o  out  3  captured cause code.
- cycle_count_o  out  32  RUN-cycle counter; frozen at capture.
- finish_o  out  1  one-cycle pulse requesting simulator finish.

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - State goes to IDLE.
  - All outputs are 0; cause_o = 0; cycle and drain counters are 0; GPIO filter is cleared.
  - Reset asserted in any state, including mid-DRAIN, aborts with no finish_o.
- Cause codes:
  - 0 none, 1 SW pass, 2 SW fail, 3 GPIO pass, 4 GPIO fail, 5 timeout, 6 abort.
  - 7 is unused.
- States:
  - IDLE -> RUN when enable_i = 1. Entering RUN loads cycle_count = 0.
  - RUN:
    - cycle_count increments by 1 each cycle and saturates at 32'hFFFFFFFF.
    - enable_i = 0 returns to IDLE and clears cycle_count and the GPIO filter.
    - An event in cycle N sets done_o, passed_o and cause_o at N+1 and freezes cycle_count at its cycle-N value.
    - On that event, go to DRAIN with drain_cnt = 0, or to FINISHED if DrainCycles = 0.
  - DRAIN:
    - drain_cnt increments each cycle.
    - When drain_cnt == DrainCycles-1, go to FINISHED.
    - With event at cycle N, finish_o is high exactly at cycle N+1+DrainCycles.
    - enable_i and all further events are ignored.
  - FINISHED:
    - finish_o is high only on the first cycle in this state, then stays 0.
    - State is terminal until reset. Outputs hold.
- Events, evaluated only in RUN, in priority order when simultaneous:
  - abort_i
  - sw_test_done_i (cause 1 if sw_test_passed_i = 1, else 2)
  - GPIO fail
  - GPIO pass
  - timeout
- GPIO glitch filter:
  - A GPIO event needs gpio_pins_i equal to the pattern in two consecutive RUN cycles.
  - The event fires on the second cycle.
  - A single-cycle match, or a pass-to-fail switch, does not fire.
- Watchdog: fires in the RUN cycle where cycle_count == TimeoutCycles, provided TimeoutCycles != 0.
- passed_o = 1 only for causes 1 and 3.
- First cause wins. A later fail never overwrites an earlier pass.
- busy_o = 1 in RUN and DRAIN; done_o = 1 in DRAIN and FINISHED.
- Fully synchronous logic: no latches, no combinational path from inputs to outputs.

Test Plan:
- SW pass: enable from cycle 0, sw_test_done_i = sw_test_passed_i = 1 at RUN cycle 100 -> cycle 101 shows done_o = 1, passed_o = 1, cause_o = 1, cycle_count_o = 100; finish_o pulses once at cycle 108 (DrainCycles = 7).
- GPIO filter: 32'hDEADBEEF for 1 cycle then 0 -> no event. Held 2 cycles -> cause_o = 3. 32'hBAADF00D held 2 cycles -> cause_o = 4, passed_o = 0.
- Priority: abort_i, sw_test_done_i (fail) and a filtered GPIO pass all in the same cycle -> cause_o = 6. A SW pass arriving during DRAIN -> cause_o stays 6, passed_o stays 0.
- Watchdog: TimeoutCycles = 50, no events -> cause_o = 5 at RUN cycle 51, cycle_count_o = 50. TimeoutCycles = 0 run for 1000 cycles -> no event.
- DrainCycles = 0: SW fail at cycle N -> done_o and finish_o both high at N+1, cause_o = 2. finish_o low at N+2 and for 100 further cycles.
- Reset/enable: rst_i high during DRAIN cycle 3 -> all outputs 0 and finish_o never pulses. enable_i low mid-RUN -> IDLE, cycle_count_o = 0; re-enable restarts from 0.

Source files
------------

// File: rtl/sim_finish_ctrl.sv
// sim_finish_ctrl
//   Simulation-only test-completion sequencer for the chip-level top.
//   Watches every source that can end a run and latches the first one that
//   wins. It then counts down a drain window so UART/log traffic can flush,
//   and finally raises a single-cycle finish request. The $finish policy
//   belongs to whoever consumes finish_o, not to this block.
//
// Ports
//   clk_i            system clock (only clock)
//   rst_i            synchronous active-high reset
//   enable_i         arms monitoring; low keeps/returns the block to IDLE
//   sw_test_done_i   SW test-status completion (level)
//   sw_test_passed_i SW pass qualifier, valid with sw_test_done_i
//   gpio_pins_i      masked GPIO outputs, compared against pass/fail patterns
//   abort_i          external fatal error (level)
//   busy_o           high in RUN or DRAIN
//   done_o           sticky: a completion cause has been captured
//   passed_o         captured cause is a pass (SW pass or GPIO pass)
//   cause_o          captured cause code (0 none .. 6 abort)
//   cycle_count_o    RUN-cycle counter, frozen at capture
//   finish_o         one-cycle finish request
module sim_finish_ctrl #(
  parameter int unsigned DrainCycles     = 7,
  parameter logic [31:0] TimeoutCycles   = 32'd10_000_000,
  parameter logic [31:0] GpioPassPattern = 32'hDEADBEEF,
  parameter logic [31:0] GpioFailPattern = 32'hBAADF00D
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        sw_test_done_i,
  input  logic        sw_test_passed_i,
  input  logic [31:0] gpio_pins_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        passed_o,
  output logic [2:0]  cause_o,
  output logic [31:0] cycle_count_o,
  output logic        finish_o
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StDrain    = 2'd2;
  localparam logic [1:0] StFinished = 2'd3;

  localparam logic [2:0] CauseNone     = 3'd0;
  localparam logic [2:0] CauseSwPass   = 3'd1;
  localparam logic [2:0] CauseSwFail   = 3'd2;
  localparam logic [2:0] CauseGpioPass = 3'd3;
  localparam logic [2:0] CauseGpioFail = 3'd4;
  localparam logic [2:0] CauseTimeout  = 3'd5;
  localparam logic [2:0] CauseAbort    = 3'd6;

  // Last drain_cnt value before FINISHED. Unused when DrainCycles is 0
  // (capture goes straight to FINISHED), so clamp to avoid wrap-around.
  localparam logic [31:0] DrainLast =
    (DrainCycles == 0) ? 32'd0 : 32'(DrainCycles - 1);
  localparam logic        NoDrain   = (DrainCycles == 0);

  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic [31:0] drain_cnt;
  logic        done_q;
  logic        passed_q;
  logic [2:0]  cause_q;
  logic        finish_q;

  // Glitch filter: "pattern matched in the previous RUN cycle".
  logic        gpio_pass_q;
  logic        gpio_fail_q;

  logic        gpio_pass_hit;
  logic        gpio_fail_hit;
  logic        timeout_hit;
  logic [2:0]  evt_cause;
  logic        evt;

  assign gpio_pass_hit = (gpio_pins_i == GpioPassPattern);
  assign gpio_fail_hit = (gpio_pins_i == GpioFailPattern);
  assign timeout_hit   = (TimeoutCycles != 32'd0) && (cycle_count == TimeoutCycles);

  // Priority encode the candidate cause for this cycle. Only consumed in RUN.
  always_comb begin
    evt_cause = CauseNone;
    if (abort_i)
      evt_cause = CauseAbort;
    else if (sw_test_done_i)
      evt_cause = sw_test_passed_i ? CauseSwPass : CauseSwFail;
    else if (gpio_fail_hit && gpio_fail_q)
      evt_cause = CauseGpioFail;
    else if (gpio_pass_hit && gpio_pass_q)
      evt_cause = CauseGpioPass;
    else if (timeout_hit)
      evt_cause = CauseTimeout;
  end

  assign evt = (evt_cause != CauseNone);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      cycle_count <= 32'd0;
      drain_cnt   <= 32'd0;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      cause_q     <= CauseNone;
      finish_q    <= 1'b0;
      gpio_pass_q <= 1'b0;
      gpio_fail_q <= 1'b0;
    end else begin
      // finish is a pulse: only the transition into FINISHED raises it.
      finish_q <= 1'b0;
      case (state)
        StIdle: begin
          cycle_count <= 32'd0;
          gpio_pass_q <= 1'b0;
          gpio_fail_q <= 1'b0;
          if (enable_i)
            state <= StRun;
        end

        StRun: begin
          // A captured cause takes precedence over a same-cycle disable so
          // that a completion is never silently dropped.
          if (evt) begin
            done_q      <= 1'b1;
            cause_q     <= evt_cause;
            passed_q    <= (evt_cause == CauseSwPass) || (evt_cause == CauseGpioPass);
            drain_cnt   <= 32'd0;
            gpio_pass_q <= 1'b0;
            gpio_fail_q <= 1'b0;
            // cycle_count deliberately not updated: frozen at the event cycle.
            if (NoDrain) begin
              state    <= StFinished;
              finish_q <= 1'b1;
            end else begin
              state <= StDrain;
            end
          end else if (!enable_i) begin
            state       <= StIdle;
            cycle_count <= 32'd0;
            gpio_pass_q <= 1'b0;
            gpio_fail_q <= 1'b0;
          end else begin
            if (cycle_count != 32'hFFFF_FFFF)
              cycle_count <= cycle_count + 32'd1;
            gpio_pass_q <= gpio_pass_hit;
            gpio_fail_q <= gpio_fail_hit;
          end
        end

        StDrain: begin
          // Inputs, including enable_i, are ignored while draining.
          drain_cnt <= drain_cnt + 32'd1;
          if (drain_cnt == DrainLast) begin
            state    <= StFinished;
            finish_q <= 1'b1;
          end
        end

        default: begin
          // FINISHED: terminal until reset, everything holds.
        end
      endcase
    end
  end

  assign busy_o        = (state == StRun) || (state == StDrain);
  assign done_o        = done_q;
  assign passed_o      = passed_q;
  assign cause_o       = cause_q;
  assign cycle_count_o = cycle_count;
  assign finish_o      = finish_q;

endmodule
